regfile_ctrl: RTL and testbench

Command-driven initiator for the register file: accepts single-beat host commands on a valid/ready channel, sequences the register file's two combinational read ports and one synchronous write port, and returns one response per command on a valid/ready channel. It sits between a host/debug or test-sequencer port and the register file instance. It supplies the read, write, read-modify-write and bulk-fill traffic the register file cannot generate itself.

---
 rtl/regfile_ctrl_pkg.sv | 33 +++
 rtl/regfile_ctrl.sv | 138 +++++++++++++
 tb/tb_regfile_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register file command controller: op encodings,
// FSM state type and default geometry.
package regfile_ctrl_pkg;

   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned NREG_DEF = 32;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_RMW_ADD = 2'b10;
   localparam logic [1:0] OP_FILL    = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
      StRmw,
      StFill,
      StResp
   } state_e;

   // Work state entered when a command with this op is accepted.
   function automatic state_e op_to_state(input logic [1:0] op);
      unique case (op)
         OP_READ:    op_to_state = StRead;
         OP_WRITE:   op_to_state = StWrite;
         OP_RMW_ADD: op_to_state = StRmw;
         default:    op_to_state = StFill;
      endcase
   endfunction

endpackage

// File: rtl/regfile_ctrl.sv
// Command-driven initiator for the register file: turns single-beat host
// commands into register file read/write port traffic and returns one
// response per command.
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned NREG = NREG_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr_a,
   input  logic [AW-1:0] cmd_addr_b,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data_a,
   output logic [DW-1:0] rsp_data_b,
   output logic          busy,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr1,
   output logic [AW-1:0] rf_addr2,
   output logic [AW-1:0] rf_addr3,
   output logic [DW-1:0] rf_wdata,
   input  logic [DW-1:0] rf_rdata1,
   input  logic [DW-1:0] rf_rdata2
);

   state_e        state_q;
   logic [AW-1:0] addr_a_q;
   logic [AW-1:0] addr_b_q;
   logic [DW-1:0] data_q;
   logic [AW-1:0] cnt_q;
   logic [DW-1:0] rsp_a_q;
   logic [DW-1:0] rsp_b_q;

   // Sum used both as the RMW write data and as its reported new value.
   logic [DW-1:0] rmw_sum;
   assign rmw_sum = rf_rdata1 + data_q;

   // FSM: command capture, per-op work cycle(s), response hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_a_q <= '0;
         addr_b_q <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         rsp_a_q  <= '0;
         rsp_b_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  addr_a_q <= cmd_addr_a;
                  addr_b_q <= cmd_addr_b;
                  data_q   <= cmd_data;
                  cnt_q    <= '0;
                  state_q  <= op_to_state(cmd_op);
               end
            end
            StRead: begin
               rsp_a_q <= rf_rdata1;
               rsp_b_q <= rf_rdata2;
               state_q <= StResp;
            end
            StWrite: begin
               rsp_a_q <= data_q;
               rsp_b_q <= '0;
               state_q <= StResp;
            end
            StRmw: begin
               rsp_a_q <= rf_rdata1;
               rsp_b_q <= rmw_sum;
               state_q <= StResp;
            end
            StFill: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(NREG - 1)) begin
                  rsp_a_q <= data_q;
                  rsp_b_q <= DW'(NREG);
                  state_q <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Register file port drive; decoded from the registered state so rf_we
   // drops together with an asynchronous reset.
   always_comb begin
      rf_we    = 1'b0;
      rf_addr1 = '0;
      rf_addr2 = '0;
      rf_addr3 = '0;
      rf_wdata = '0;
      unique case (state_q)
         StRead: begin
            rf_addr1 = addr_a_q;
            rf_addr2 = addr_b_q;
         end
         StWrite: begin
            rf_we    = 1'b1;
            rf_addr3 = addr_a_q;
            rf_wdata = data_q;
         end
         StRmw: begin
            rf_we    = 1'b1;
            rf_addr1 = addr_a_q;
            rf_addr3 = addr_a_q;
            rf_wdata = rmw_sum;
         end
         StFill: begin
            rf_we    = 1'b1;
            rf_addr3 = cnt_q;
            rf_wdata = data_q;
         end
         default: ;
      endcase
   end

   assign cmd_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign rsp_valid  = (state_q == StResp);
   assign rsp_data_a = rsp_a_q;
   assign rsp_data_b = rsp_b_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: a behavioural register file is
// attached to the controller and a word-array reference model predicts
// every response and register content.
module tb_regfile_ctrl;
   import regfile_ctrl_pkg::*;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr_a;
   logic [AW-1:0] cmd_addr_b;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data_a;
   logic [DW-1:0] rsp_data_b;
   logic          busy;
   logic          rf_we;
   logic [AW-1:0] rf_addr1;
   logic [AW-1:0] rf_addr2;
   logic [AW-1:0] rf_addr3;
   logic [DW-1:0] rf_wdata;
   logic [DW-1:0] rf_rdata1;
   logic [DW-1:0] rf_rdata2;

   int checks = 0;
   int errors = 0;

   // Reference model of register contents.
   logic [DW-1:0] ref_mem [NREG];

   regfile_ctrl #(.DW(DW), .AW(AW), .NREG(NREG)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_addr_a (cmd_addr_a),
      .cmd_addr_b (cmd_addr_b),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data_a (rsp_data_a),
      .rsp_data_b (rsp_data_b),
      .busy       (busy),
      .rf_we      (rf_we),
      .rf_addr1   (rf_addr1),
      .rf_addr2   (rf_addr2),
      .rf_addr3   (rf_addr3),
      .rf_wdata   (rf_wdata),
      .rf_rdata1  (rf_rdata1),
      .rf_rdata2  (rf_rdata2)
   );

   // Behavioural register file: combinational reads, synchronous write,
   // every word powers up as 1 and is not touched by rst_n.
   logic [DW-1:0] rf_mem [NREG];
   initial for (int i = 0; i < NREG; i++) rf_mem[i] = 32'h1;
   assign rf_rdata1 = rf_mem[rf_addr1];
   assign rf_rdata2 = rf_mem[rf_addr2];
   always @(posedge clk) if (rf_we) rf_mem[rf_addr3] <= rf_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply a command to the reference model and return the expected response.
   task automatic model(input logic [1:0] op, input int a, input int b, input logic [DW-1:0] d,
                        output logic [DW-1:0] ea, output logic [DW-1:0] eb);
      case (op)
         OP_READ: begin
            ea = ref_mem[a];
            eb = ref_mem[b];
         end
         OP_WRITE: begin
            ref_mem[a] = d;
            ea = d;
            eb = 0;
         end
         OP_RMW_ADD: begin
            ea = ref_mem[a];
            eb = ea + d;
            ref_mem[a] = eb;
         end
         default: begin
            for (int i = 0; i < NREG; i++) ref_mem[i] = d;
            ea = d;
            eb = NREG;
         end
      endcase
   endtask

   // Issue one command starting 1 time unit after a rising edge while idle;
   // hold rsp_ready low for `hold` extra cycles once the response appears.
   // Returns 1 time unit after the handshake edge.
   task automatic run_cmd(input logic [1:0] op, input int a, input int b,
                          input logic [DW-1:0] d, input int hold);
      logic [DW-1:0] ea, eb, ra, rb;
      int lat, we_cnt, exp_lat, exp_we;
      bit got;
      model(op, a, b, d, ea, eb);
      exp_lat = (op == OP_FILL) ? NREG + 1 : 2;
      exp_we  = (op == OP_FILL) ? NREG : ((op == OP_READ) ? 0 : 1);
      check("cmd_ready_idle", 32'(cmd_ready), 32'h1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_addr_a = AW'(a);
      cmd_addr_b = AW'(b);
      cmd_data   = d;
      rsp_ready  = (hold == 0);
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'($urandom);
      cmd_data   = $urandom;
      check("busy_after_accept", 32'(busy), 32'h1);
      lat = 1;
      we_cnt = 0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (rsp_valid) begin
            got = 1;
         end else begin
            if (rf_we) begin
               if (op == OP_FILL) check("fill_addr3", 32'(rf_addr3), 32'(we_cnt));
               else check("wr_addr3", 32'(rf_addr3), 32'(a));
               we_cnt++;
            end
            @(posedge clk); #1;
            lat++;
         end
      end
      check("rsp_seen", 32'(got), 32'h1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("we_cycles", 32'(we_cnt), 32'(exp_we));
      ra = rsp_data_a;
      rb = rsp_data_b;
      check("rsp_data_a", ra, ea);
      check("rsp_data_b", rb, eb);
      for (int j = 0; j < hold; j++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(rsp_valid), 32'h1);
         check("bp_data_a", rsp_data_a, ra);
         check("bp_data_b", rsp_data_b, rb);
         check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
         check("bp_rf_we", 32'(rf_we), 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rsp_pulse_end", 32'(rsp_valid), 32'h0);
   endtask

   initial begin
      logic [DW-1:0] fill_v;
      int a, b;
      logic [1:0] op;
      for (int i = 0; i < NREG; i++) ref_mem[i] = 32'h1;
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_addr_a = '0;
      cmd_addr_b = '0;
      cmd_data   = '0;
      rsp_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rf_we", 32'(rf_we), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_a", rsp_data_a, 32'h0);
      check("rst_rsp_b", rsp_data_b, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed plan.
      run_cmd(OP_READ, 3, 7, 32'h0, 0);
      run_cmd(OP_WRITE, 5, 0, 32'hDEADBEEF, 0);
      run_cmd(OP_READ, 5, 0, 32'h0, 0);
      run_cmd(OP_RMW_ADD, 9, 0, 32'hFFFFFFFF, 0);
      run_cmd(OP_READ, 9, 9, 32'h0, 0);
      run_cmd(OP_FILL, 0, 0, 32'hA5A5A5A5, 0);
      run_cmd(OP_READ, 0, 31, 32'h0, 0);
      // Backpressure, then an immediate follow-on command.
      run_cmd(OP_RMW_ADD, 4, 0, 32'h00000010, 4);
      run_cmd(OP_READ, 4, 31, 32'h0, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 2));
         a  = $urandom_range(0, NREG - 1);
         b  = $urandom_range(0, NREG - 1);
         run_cmd(op, a, b, $urandom, $urandom_range(0, 2));
      end
      // Make registers 10..31 distinct from the next fill value.
      for (int i = 10; i < NREG; i++) run_cmd(OP_WRITE, i, 0, $urandom | 32'h1, 0);

      // Reset in the middle of a FILL, with counter at 10.
      fill_v     = 32'h5A5A0000 | 32'($urandom_range(0, 16'hFFFF));
      cmd_valid  = 1'b1;
      cmd_op     = OP_FILL;
      cmd_data   = fill_v;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midfill_we", 32'(rf_we), 32'h1);
      check("midfill_addr3", 32'(rf_addr3), 32'd10);
      rst_n = 1'b0;
      #1;
      check("rst_async_we", 32'(rf_we), 32'h0);
      check("rst_async_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 10; i++) ref_mem[i] = fill_v;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_ready", 32'(cmd_ready), 32'h1);
      check("post_rst_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      for (int i = 0; i < NREG; i += 2) run_cmd(OP_READ, i, i + 1, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
